// File: rtl/gs_basis_extract.sv
// rtl/gs_basis_extract.sv - scans reduced rows and streams non-zero rows as basis vectors
//
// Purpose: after Gaussian elimination, walk the DAT_D rows of row memory,
// emit every non-zero row on a valid/ready port, then report the rank and
// whether it equals the expected dimension d.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_b      in   1      asynchronous active-low reset
//   start      in   1      scan request pulse, honoured only while idle
//   finish     out  1      one-cycle pulse when the scan completes
//   mem_din    in   DAT_W  row memory read data (READ_DELAY cycles after mem_addr)
//   mem_addr   out  AW     row memory read address
//   mem_rw     out  1      row memory write enable, constant 0
//   basis_vld  out  1      basis_dat/basis_idx valid
//   basis_rdy  in   1      consumer ready
//   basis_dat  out  DAT_W  non-zero reduced row
//   basis_idx  out  AW     row address of basis_dat
//   rank       out  RW     count of non-zero rows, held after finish
//   rank_ok    out  1      rank == d, updated with finish, held after
module gs_basis_extract #(
  parameter int DAT_W      = 8,
  parameter int DAT_D      = 4,
  parameter int d          = 2,
  parameter int READ_DELAY = 2,
  localparam int AW = (DAT_D > 1) ? $clog2(DAT_D) : 1,
  localparam int RW = $clog2(DAT_D + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  output logic             finish,
  input  logic [DAT_W-1:0] mem_din,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rw,
  output logic             basis_vld,
  input  logic             basis_rdy,
  output logic [DAT_W-1:0] basis_dat,
  output logic [AW-1:0]    basis_idx,
  output logic [RW-1:0]    rank,
  output logic             rank_ok
);

  localparam int WCW = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(READ_DELAY - 1);
  localparam logic [AW-1:0]  ROW_LAST  = AW'(DAT_D - 1);
  localparam int unsigned    D_EXP     = d;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    OUT,
    DONE
  } state_t;

  state_t           state;
  logic [AW-1:0]    row;
  logic [WCW-1:0]   wait_cnt;
  logic [AW-1:0]    row_inc;
  logic [RW-1:0]    rank_inc;

  assign row_inc  = row + AW'(1);
  assign rank_inc = rank + RW'(1);
  assign mem_rw   = 1'b0;

  // mem_addr is loaded on entry to ISSUE, so the address is on the bus for
  // the whole ISSUE cycle. The read returns READ_DELAY cycles later, which is
  // the last cycle spent in WAIT; capture happens on the edge that ends it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      row       <= '0;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      finish    <= 1'b0;
      basis_vld <= 1'b0;
      basis_dat <= '0;
      basis_idx <= '0;
      rank      <= '0;
      rank_ok   <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rank     <= '0;
            rank_ok  <= 1'b0;
            row      <= '0;
            mem_addr <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            basis_dat <= mem_din;
            basis_idx <= row;
            state     <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        CHECK: begin
          if (basis_dat != '0) begin
            basis_vld <= 1'b1;
            state     <= OUT;
          end else if (row == ROW_LAST) begin
            // finish is raised on entry to DONE so the pulse occupies DONE
            finish  <= 1'b1;
            rank_ok <= (32'(rank) == D_EXP);
            state   <= DONE;
          end else begin
            row      <= row_inc;
            mem_addr <= row_inc;
            state    <= ISSUE;
          end
        end
        OUT: begin
          if (basis_rdy) begin
            basis_vld <= 1'b0;
            rank      <= rank_inc;
            if (row == ROW_LAST) begin
              // rank is updated on this same edge, so compare the new count
              finish  <= 1'b1;
              rank_ok <= (32'(rank_inc) == D_EXP);
              state   <= DONE;
            end else begin
              row      <= row_inc;
              mem_addr <= row_inc;
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gs_basis_extract.sv
// tb/tb_gs_basis_extract.sv - directed vector bench for gs_basis_extract
module tb_gs_basis_extract;

  logic       clk;
  logic       rst_b;
  logic       start_a, start_b;
  logic       basis_rdy;
  logic       sel4;

  logic       finish_a, rw_a, vld_a, ok_a;
  logic [7:0] din_a, dat_a;
  logic [1:0] addr_a, idx_a;
  logic [2:0] rank_a;

  logic       finish_b, rw_b, vld_b, ok_b;
  logic [7:0] din_b, dat_b;
  logic [1:0] addr_b, idx_b;
  logic [2:0] rank_b;

  gs_basis_extract #(.DAT_W(8), .DAT_D(4), .d(2), .READ_DELAY(2)) dut_a (
    .clk(clk), .rst_b(rst_b), .start(start_a), .finish(finish_a),
    .mem_din(din_a), .mem_addr(addr_a), .mem_rw(rw_a),
    .basis_vld(vld_a), .basis_rdy(basis_rdy), .basis_dat(dat_a),
    .basis_idx(idx_a), .rank(rank_a), .rank_ok(ok_a)
  );

  gs_basis_extract #(.DAT_W(8), .DAT_D(4), .d(2), .READ_DELAY(4)) dut_b (
    .clk(clk), .rst_b(rst_b), .start(start_b), .finish(finish_b),
    .mem_din(din_b), .mem_addr(addr_b), .mem_rw(rw_b),
    .basis_vld(vld_b), .basis_rdy(basis_rdy), .basis_dat(dat_b),
    .basis_idx(idx_b), .rank(rank_b), .rank_ok(ok_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // row memory with a fixed read pipeline per instance
  logic [7:0] mem [4];
  logic [7:0] pa  [2];
  logic [7:0] pb  [4];
  always @(posedge clk) begin
    pa[0] <= mem[addr_a];
    pa[1] <= pa[0];
    pb[0] <= mem[addr_b];
    for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
  end
  assign din_a = pa[1];
  assign din_b = pb[3];

  logic       m_fin, m_rw, m_vld, m_ok;
  logic [7:0] m_dat;
  logic [1:0] m_addr, m_idx;
  logic [2:0] m_rank;
  assign m_fin  = sel4 ? finish_b : finish_a;
  assign m_rw   = sel4 ? rw_b     : rw_a;
  assign m_vld  = sel4 ? vld_b    : vld_a;
  assign m_ok   = sel4 ? ok_b     : ok_a;
  assign m_dat  = sel4 ? dat_b    : dat_a;
  assign m_addr = sel4 ? addr_b   : addr_a;
  assign m_idx  = sel4 ? idx_b    : idx_a;
  assign m_rank = sel4 ? rank_b   : rank_a;

  typedef struct {
    logic [3:0][7:0] rows;   // rows[0] is memory row 0
    int              stall;  // cycles basis_rdy is held low on each beat
    bit              rd4;    // use the READ_DELAY=4 instance
    int              n;
    logic [3:0][7:0] dat;
    logic [3:0][1:0] idx;
    int              rank;
    int              ok;
    int              fin;    // cycle finish is seen; start is sampled in cycle 0
  } vec_t;

  vec_t vecs [7];

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] obs_dat [8];
  logic [1:0] obs_idx [8];
  int         obs_n, obs_fin_cyc, obs_fin_cnt, obs_rank, obs_ok;
  int         stab_err, tim_err, post_vld, rw_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rows(input logic [3:0][7:0] r);
    for (int i = 0; i < 4; i++) mem[i] = r[i];
  endtask

  task automatic run_scan(input int stall, input bit extra);
    int         sl, last_cyc, tail_end, rd;
    logic [1:0] last_addr;
    logic [7:0] hd;
    logic [1:0] hi;
    bit         prev_vld, held;
    rd = sel4 ? 4 : 2;
    obs_n = 0; obs_fin_cyc = -1; obs_fin_cnt = 0;
    stab_err = 0; tim_err = 0; post_vld = 0; rw_err = 0;
    for (int i = 0; i < 8; i++) begin obs_dat[i] = '0; obs_idx[i] = '0; end
    @(negedge clk);
    basis_rdy = 1'b1;
    if (sel4) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    sl = stall; prev_vld = 0; held = 0; hd = '0; hi = '0;
    last_addr = m_addr; last_cyc = 1; tail_end = 200;
    for (int cyc = 1; cyc <= tail_end; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (m_rw !== 1'b0) rw_err++;
      if (m_addr !== last_addr) begin last_addr = m_addr; last_cyc = cyc; end
      if (obs_fin_cyc >= 0 && m_vld) post_vld++;
      if (m_fin) begin
        obs_fin_cnt++;
        if (obs_fin_cyc < 0) begin obs_fin_cyc = cyc; tail_end = cyc + 10; end
      end
      // address on the bus, READ_DELAY cycles of read, capture, CHECK, then OUT
      if (m_vld && !prev_vld && (cyc - last_cyc) != rd + 2) tim_err++;
      if (m_vld) begin
        if (held && (m_dat !== hd || m_idx !== hi)) stab_err++;
        if (!held) begin held = 1; hd = m_dat; hi = m_idx; end
        if (sl > 0) begin
          basis_rdy = 1'b0;
          sl--;
        end else begin
          basis_rdy = 1'b1;
          if (obs_n < 8) begin obs_dat[obs_n] = m_dat; obs_idx[obs_n] = m_idx; end
          obs_n++;
          held = 0;
          sl = stall;
        end
      end else begin
        basis_rdy = 1'b1;
      end
      if (extra && (m_vld || m_fin)) begin
        if (sel4) start_b = 1'b1; else start_a = 1'b1;
      end
      prev_vld = m_vld;
    end
    start_a = 1'b0; start_b = 1'b0;
    obs_rank = int'(m_rank);
    obs_ok   = int'(m_ok);
  endtask

  task automatic compare_vector(input int v, input string tag);
    chk({tag, ".finish_cycle"}, obs_fin_cyc, vecs[v].fin);
    chk({tag, ".finish_pulses"}, obs_fin_cnt, 1);
    chk({tag, ".rank"}, obs_rank, vecs[v].rank);
    chk({tag, ".rank_ok"}, obs_ok, vecs[v].ok);
    chk({tag, ".beats"}, obs_n, vecs[v].n);
    for (int i = 0; i < vecs[v].n; i++) begin
      chk($sformatf("%s.beat%0d_dat", tag, i), obs_dat[i], vecs[v].dat[i]);
      chk($sformatf("%s.beat%0d_idx", tag, i), obs_idx[i], vecs[v].idx[i]);
    end
    chk({tag, ".stall_stability_errs"}, stab_err, 0);
    chk({tag, ".read_timing_errs"}, tim_err, 0);
    chk({tag, ".vld_after_finish"}, post_vld, 0);
    chk({tag, ".mem_rw_errs"}, rw_err, 0);
  endtask

  initial begin
    int fin_seen;
    rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0; basis_rdy = 1'b0; sel4 = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    // 0: scenario 1
    vecs[0] = '{rows: {8'h00, 8'h42, 8'h00, 8'h81}, stall: 0, rd4: 0, n: 2,
                dat: {8'h00, 8'h00, 8'h42, 8'h81}, idx: {2'd0, 2'd0, 2'd2, 2'd0},
                rank: 2, ok: 1, fin: 19};
    // 1: all-zero matrix
    vecs[1] = '{rows: 32'h0, stall: 0, rd4: 0, n: 0, dat: 32'h0, idx: 8'h0,
                rank: 0, ok: 0, fin: 17};
    // 2: full rank with consumer stalls
    vecs[2] = '{rows: {8'h08, 8'h04, 8'h02, 8'h01}, stall: 5, rd4: 0, n: 4,
                dat: {8'h08, 8'h04, 8'h02, 8'h01}, idx: {2'd3, 2'd2, 2'd1, 2'd0},
                rank: 4, ok: 0, fin: 41};
    // 3: only the last row non-zero
    vecs[3] = '{rows: {8'hFF, 8'h00, 8'h00, 8'h00}, stall: 0, rd4: 0, n: 1,
                dat: {8'h00, 8'h00, 8'h00, 8'hFF}, idx: {2'd0, 2'd0, 2'd0, 2'd3},
                rank: 1, ok: 0, fin: 18};
    // 4: rank above d
    vecs[4] = '{rows: {8'h33, 8'h00, 8'h22, 8'h11}, stall: 0, rd4: 0, n: 3,
                dat: {8'h00, 8'h33, 8'h22, 8'h11}, idx: {2'd0, 2'd3, 2'd1, 2'd0},
                rank: 3, ok: 0, fin: 20};
    // 5: zero first and last rows
    vecs[5] = '{rows: {8'h00, 8'h5A, 8'hC3, 8'h00}, stall: 0, rd4: 0, n: 2,
                dat: {8'h00, 8'h00, 8'h5A, 8'hC3}, idx: {2'd0, 2'd0, 2'd2, 2'd1},
                rank: 2, ok: 1, fin: 19};
    // 6: scenario 1 through the READ_DELAY=4 instance
    vecs[6] = '{rows: {8'h00, 8'h42, 8'h00, 8'h81}, stall: 0, rd4: 1, n: 2,
                dat: {8'h00, 8'h00, 8'h42, 8'h81}, idx: {2'd0, 2'd0, 2'd2, 2'd0},
                rank: 2, ok: 1, fin: 27};

    repeat (3) @(negedge clk);
    chk("reset_a", {finish_a, vld_a, dat_a, idx_a, rank_a, ok_a, addr_a, rw_a}, 0);
    chk("reset_b", {finish_b, vld_b, dat_b, idx_b, rank_b, ok_b, addr_b, rw_b}, 0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      sel4 = vecs[v].rd4;
      set_rows(vecs[v].rows);
      run_scan(vecs[v].stall, 1'b0);
      compare_vector(v, $sformatf("vec%0d", v));
    end

    // start pulses during OUT and during DONE must be dropped
    sel4 = 1'b0;
    set_rows(vecs[0].rows);
    run_scan(0, 1'b1);
    compare_vector(0, "start_ignored");

    // reset in the first WAIT cycle of row 1, then a clean rescan
    set_rows(vecs[0].rows);
    basis_rdy = 1'b1;
    fin_seen = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    if (finish_a) fin_seen++;
    repeat (6) begin
      @(negedge clk);
      if (finish_a) fin_seen++;
    end
    chk("midscan.rank_before_reset", rank_a, 1);
    rst_b = 1'b0;
    #1;
    chk("midscan.reset_values",
        {finish_a, vld_a, dat_a, idx_a, rank_a, ok_a, addr_a, rw_a}, 0);
    repeat (3) begin
      @(negedge clk);
      if (finish_a) fin_seen++;
    end
    rst_b = 1'b1;
    chk("midscan.no_finish", fin_seen, 0);
    run_scan(0, 1'b0);
    compare_vector(0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
